uart_stdin: RTL



---
 rtl/uart_stdin.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/uart_stdin.sv
// rtl/uart_stdin.sv - 8N1 UART receiver with show-ahead byte FIFO for the CPU stdin path
module uart_stdin #(
  parameter int BAUD    = 104,
  parameter int FIFO_AW = 4
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               rx,
  input  logic               stdin_rd,
  output logic [7:0]         stdin_data,
  output logic               stdin_valid,
  output logic [FIFO_AW:0]   stdin_count,
  input  logic               err_clr,
  output logic               frame_err,
  output logic               overrun
);

  localparam int DEPTH = 1 << FIFO_AW;
  localparam int CW    = (BAUD > 2) ? $clog2(BAUD) : 1;

  localparam logic [CW-1:0]      HALF_M1 = CW'(BAUD / 2 - 1);
  localparam logic [CW-1:0]      FULL_M1 = CW'(BAUD - 1);
  localparam logic [FIFO_AW:0]   DEPTH_C = (FIFO_AW + 1)'(DEPTH);
  localparam logic [FIFO_AW:0]   CNT_ONE = (FIFO_AW + 1)'(1);
  localparam logic [FIFO_AW-1:0] PTR_ONE = FIFO_AW'(1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  logic               rx_meta_q, rx_s_q;
  state_t             state_q;
  logic [CW-1:0]      cnt_q;
  logic [2:0]         bit_q;
  logic [7:0]         shift_q;
  logic               push_q;
  logic               stop_bad;

  logic [7:0]         mem_q [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [FIFO_AW:0]   count_q, count_d;
  logic               frame_err_q, overrun_q;
  logic               fifo_full, do_pop, do_push, ovr_evt;

  // Two-flop synchroniser; idles high so reset never looks like a start bit
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rx_s_q    <= rx_meta_q;
    end
  end

  // Receive FSM: half-bit start check, then full-bit steps to each bit centre
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      push_q  <= 1'b0;
    end else begin
      push_q <= 1'b0;
      case (state_q)
        IDLE: begin
          cnt_q <= '0;
          if (!rx_s_q) state_q <= START;
        end
        START: begin
          if (cnt_q == HALF_M1) begin
            cnt_q   <= '0;
            bit_q   <= '0;
            state_q <= rx_s_q ? IDLE : DATA;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        DATA: begin
          if (cnt_q == FULL_M1) begin
            cnt_q   <= '0;
            shift_q <= {rx_s_q, shift_q[7:1]};
            bit_q   <= bit_q + 1'b1;
            if (bit_q == 3'd7) state_q <= STOP;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        STOP: begin
          if (cnt_q == FULL_M1) begin
            cnt_q   <= '0;
            state_q <= IDLE;
            push_q  <= rx_s_q;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign stop_bad  = (state_q == STOP) && (cnt_q == FULL_M1) && !rx_s_q;
  assign fifo_full = (count_q == DEPTH_C);
  assign do_pop    = stdin_rd && (count_q != '0);
  // A full FIFO still accepts a byte when the head leaves in the same cycle
  assign do_push   = push_q && (!fifo_full || do_pop);
  assign ovr_evt   = push_q && fifo_full && !do_pop;

  // Next-state pointer and occupancy arithmetic
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
    if (do_push && !do_pop) count_d = count_q + CNT_ONE;
    if (do_pop && !do_push) count_d = count_q - CNT_ONE;
  end

  // FIFO storage and pointers; storage cleared so the head reads zero after reset
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) mem_q[wr_ptr_q] <= shift_q;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Sticky error flags; a new event outranks a simultaneous clear
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      if (stop_bad)     frame_err_q <= 1'b1;
      else if (err_clr) frame_err_q <= 1'b0;
      if (ovr_evt)      overrun_q   <= 1'b1;
      else if (err_clr) overrun_q   <= 1'b0;
    end
  end

  assign stdin_data  = mem_q[rd_ptr_q];
  assign stdin_valid = (count_q != '0);
  assign stdin_count = count_q;
  assign frame_err   = frame_err_q;
  assign overrun     = overrun_q;

endmodule
